// File: rtl/game_ctrl_lives_if.sv
// Player-input / game-status bundle. master drives keys and collisions, slave (the controller) drives status.
// The paused signal exists only when GAME_CTRL_PAUSE_EN is defined.
interface game_ctrl_lives_if #(
    parameter int NKEY = 4,
    parameter int NHIT = 2
);
    logic [NKEY-1:0] key_press;
    logic [NHIT-1:0] hit;
    logic [1:0]      gameStatus;
    logic            dieFlash;
    logic            restart;
    logic [3:0]      lives_left;
`ifdef GAME_CTRL_PAUSE_EN
    logic            paused;

    modport master (output key_press, hit,
                    input  gameStatus, dieFlash, restart, lives_left, paused);
    modport slave  (input  key_press, hit,
                    output gameStatus, dieFlash, restart, lives_left, paused);
`else
    modport master (output key_press, hit,
                    input  gameStatus, dieFlash, restart, lives_left);
    modport slave  (input  key_press, hit,
                    output gameStatus, dieFlash, restart, lives_left);
`endif
endinterface

// File: rtl/game_ctrl_lives.sv
// Snake-game status/lives controller: START -> PLAY -> DIE (blinking) -> PLAY or OVER; all outputs registered, one cycle from input to status.
// No backpressure: inputs are sampled every cycle. Optional pause in PLAY when GAME_CTRL_PAUSE_EN is defined.
module game_ctrl_lives #(
    parameter int NKEY          = 4,
    parameter int NHIT          = 2,
    parameter int LIVES         = 3,
    parameter int FLASH_HALF    = 25000000,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic             clk,
    input  logic             rst,
    game_ctrl_lives_if.slave bus
);
    // A one-cycle half period still needs a 1-bit counter to exist.
    localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int TW = $clog2(FLASH_TOGGLES + 1);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_PLAY  = 2'b01,
        ST_DIE   = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tog_q, tog_d;
    logic          flash_q, flash_d;
    logic          restart_q, restart_d;
    logic [3:0]    lives_q, lives_d;
    logic          any_key, any_hit, hit_live, wrap;

    assign any_key = |bus.key_press[NKEY-1:0];
    assign any_hit = |bus.hit[NHIT-1:0];
    assign wrap    = (cnt_q == CW'(FLASH_HALF - 1));

`ifdef GAME_CTRL_PAUSE_EN
    logic paused_q, paused_d;
    assign hit_live = any_hit && !paused_q;
`else
    assign hit_live = any_hit;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tog_d     = tog_q;
        flash_d   = flash_q;
        restart_d = 1'b0;
        lives_d   = lives_q;
        case (state_q)
            ST_START: begin
                if (any_key) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (hit_live) begin
                    state_d = ST_DIE;
                    cnt_d   = '0;
                    tog_d   = '0;
                    flash_d = 1'b0;
                    if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
                end
            end
            ST_DIE: begin
                if (wrap) begin
                    cnt_d   = '0;
                    flash_d = ~flash_q;
                    tog_d   = tog_q + 1'b1;
                    // Even toggle count means the blink naturally ends low.
                    if (tog_q == TW'(FLASH_TOGGLES - 1)) begin
                        tog_d     = '0;
                        flash_d   = 1'b0;
                        state_d   = (lives_q != 4'd0) ? ST_PLAY : ST_OVER;
                        restart_d = (lives_q != 4'd0);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OVER: begin
                if (any_key) begin
                    state_d   = ST_START;
                    lives_d   = 4'(LIVES);
                    restart_d = 1'b1;
                end
            end
            default: state_d = ST_START;
        endcase
    end

`ifdef GAME_CTRL_PAUSE_EN
    // A hit wins over the pause key; any exit from PLAY drops the pause.
    always_comb begin
        paused_d = paused_q;
        if (state_q != ST_PLAY || hit_live) begin
            paused_d = 1'b0;
        end else if (bus.key_press[NKEY-1]) begin
            paused_d = ~paused_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_START;
            cnt_q     <= '0;
            tog_q     <= '0;
            flash_q   <= 1'b0;
            restart_q <= 1'b0;
            lives_q   <= 4'(LIVES);
`ifdef GAME_CTRL_PAUSE_EN
            paused_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tog_q     <= tog_d;
            flash_q   <= flash_d;
            restart_q <= restart_d;
            lives_q   <= lives_d;
`ifdef GAME_CTRL_PAUSE_EN
            paused_q  <= paused_d;
`endif
        end
    end

    assign bus.gameStatus = state_q;
    assign bus.dieFlash   = flash_q;
    assign bus.restart    = restart_q;
    assign bus.lives_left = lives_q;
`ifdef GAME_CTRL_PAUSE_EN
    assign bus.paused     = paused_q;
`endif

endmodule

// File: tb/tb_game_ctrl_lives.sv
// Scoreboard bench: the stimulus task runs a reference model and queues the expected outputs; a monitor compares each cycle.
module tb_game_ctrl_lives;
    localparam int NKEY = 4;
    localparam int NHIT = 2;
    localparam int LIVES = 3;
    localparam int FH = 2;
    localparam int FT = 6;
`ifdef GAME_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] st;
        logic       flash;
        logic       restart;
        logic [3:0] lives;
        logic       paused;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    game_ctrl_lives_if #(.NKEY(NKEY), .NHIT(NHIT)) bus ();

    game_ctrl_lives #(
        .NKEY(NKEY), .NHIT(NHIT), .LIVES(LIVES),
        .FLASH_HALF(FH), .FLASH_TOGGLES(FT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model state: game phase, lives, cycles spent in the current death, pause flag.
    int m_st    = 0;
    int m_lives = LIVES;
    int m_die_t = 0;
    int m_pause = 0;

    task automatic step(input logic r, input logic [NKEY-1:0] k, input logic [NHIT-1:0] h);
        obs_t e;
        int   rs;
        rs = 0;
        rst = r;
        bus.key_press = k;
        bus.hit = h;
        if (!r) begin
            m_st = 0; m_lives = LIVES; m_die_t = 0; m_pause = 0;
        end else begin
            case (m_st)
                0: if (k != 0) m_st = 1;
                1: begin
                    if (h != 0 && m_pause == 0) begin
                        m_st = 2;
                        if (m_lives > 0) m_lives = m_lives - 1;
                        m_die_t = 0;
                        m_pause = 0;
                    end else if (PAUSE_EN && k[NKEY-1]) begin
                        m_pause = 1 - m_pause;
                    end
                end
                2: begin
                    m_die_t = m_die_t + 1;
                    if (m_die_t == FH * FT) begin
                        m_die_t = 0;
                        if (m_lives > 0) begin m_st = 1; rs = 1; end
                        else m_st = 3;
                    end
                end
                default: if (k != 0) begin m_st = 0; m_lives = LIVES; rs = 1; end
            endcase
        end
        e.st      = 2'(m_st);
        e.flash   = (m_st == 2) ? 1'((m_die_t / FH) % 2) : 1'b0;
        e.restart = 1'(rs);
        e.lives   = 4'(m_lives);
        e.paused  = 1'(m_pause);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0, '0);
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.st      = bus.gameStatus;
                a.flash   = bus.dieFlash;
                a.restart = bus.restart;
                a.lives   = bus.lives_left;
`ifdef GAME_CTRL_PAUSE_EN
                a.paused  = bus.paused;
`else
                a.paused  = 1'b0;
`endif
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_%0d outputs: got st=%b flash=%b restart=%b lives=%0d paused=%b, want st=%b flash=%b restart=%b lives=%0d paused=%b",
                             cyc, a.st, a.flash, a.restart, a.lives, a.paused,
                             e.st, e.flash, e.restart, e.lives, e.paused);
                end
            end
        end
    end

    initial begin
        logic            r;
        logic [NKEY-1:0] k;
        logic [NHIT-1:0] h;
        bus.key_press = '0;
        bus.hit = '0;

        step(1'b0, '0, '0);
        step(1'b0, 4'b0001, 2'b11);
        idle(2);
        step(1'b1, 4'b0001, '0);            // START -> PLAY
        idle(3);
        step(1'b1, 4'b0001, 2'b01);         // hit and key together: hit wins
        idle(14);                           // full blink, back to PLAY with restart
`ifdef GAME_CTRL_PAUSE_EN
        step(1'b1, 4'b1000, '0);            // pause
        step(1'b1, 4'b0001, 2'b01);
        step(1'b1, '0, 2'b11);
        step(1'b1, 4'b1000, '0);            // unpause
        step(1'b1, 4'b1000, '0);            // pause again
        step(1'b1, 4'b1000, 2'b01);         // hit ignored, key unpauses
        step(1'b1, '0, 2'b01);              // now dies
        idle(14);
`endif
        step(1'b1, '0, 2'b10);
        idle(2);
        step(1'b0, '0, '0);                 // reset during the third blink cycle
        idle(2);
        step(1'b1, 4'b0010, '0);
        for (int d = 0; d < LIVES; d++) begin
            step(1'b1, '0, 2'b10);
            idle(FH * FT + 1);
        end
        idle(2);                            // OVER holds without a key
        step(1'b1, 4'b0100, '0);            // OVER -> START with lives reload
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) != 0);
            k = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            h = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b0;
            step(r, k, h);
        end
        idle(1);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
